// File: rtl/neighbor_sink_in_other_cluster_pkg.sv
// -----------------------------------------------------------------------------
// neighbor_sink_in_other_cluster_pkg
// Shared constants for the neighbor-sink scanner: data word width, the byte
// addresses of every table it touches in the shared word memory, the
// per-neighbor sinkIDs stride and the scanner FSM state encoding.
// -----------------------------------------------------------------------------
package neighbor_sink_in_other_cluster_pkg;

    localparam int WORD_WIDTH = 16;

    // Byte addresses; memory words sit on a stride of 2.
    localparam int FLAGS_ADDR            = 'h004;
    localparam int KNOWN_SINKS_ADDR      = 'h008;
    localparam int CLUSTER_ID_ADDR       = 'h0C8;
    localparam int SINK_IDS_ADDR         = 'h248;
    localparam int KNOWN_SINK_COUNT_ADDR = 'h688;
    localparam int NEIGHBOR_COUNT_ADDR   = 'h68A;
    localparam int SINK_ID_COUNT_ADDR    = 'h68E;

    // Byte distance between sinkIDs rows of consecutive neighbors.
    localparam int SINK_IDS_STRIDE       = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_KCNT,
        S_RD_NCNT,
        S_RD_CID,
        S_RD_SCNT,
        S_RD_SID,
        S_RD_KS,
        S_NEXT_NBR,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/neighbor_sink_in_other_cluster_if.sv
// -----------------------------------------------------------------------------
// neighbor_sink_in_other_cluster_if
// Shared word-memory port. The scanner is the master while busy.
//   address      : byte address (master -> memory)
//   wr_en        : write strobe (master -> memory)
//   mem_data_in  : write data   (master -> memory)
//   mem_data_out : read data, valid one cycle after address (memory -> master)
// -----------------------------------------------------------------------------
interface neighbor_sink_in_other_cluster_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int WORD_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] mem_data_in;
    logic [WORD_WIDTH-1:0] mem_data_out;

    modport master (
        output address,
        output wr_en,
        output mem_data_in,
        input  mem_data_out
    );

    modport slave (
        input  address,
        input  wr_en,
        input  mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/neighbor_sink_in_other_cluster.sv
// -----------------------------------------------------------------------------
// neighbor_sink_in_other_cluster
// Once the sink list is fixed, scans the neighbor table for any neighbor in a
// different cluster that advertises a sink also present in knownSinks. The
// result is latched in forAggregation2, written back to the flag word at 0x004,
// and completion is signalled on done_neighborSinkInOtherCluster.
//
// Ports:
//   clock                           : rising-edge clock
//   nrst                            : asynchronous active-low reset
//   en                              : start pulse
//   done_fixSinkList                : upstream completion, gates start
//   MY_CLUSTER_ID                   : this node's cluster ID
//   mem                             : shared memory port (master modport)
//   forAggregation2                 : result flag
//   done_neighborSinkInOtherCluster : completion
// -----------------------------------------------------------------------------
module neighbor_sink_in_other_cluster
    import neighbor_sink_in_other_cluster_pkg::*;
#(
    parameter int ADDR_WIDTH             = 11,
    parameter int MAX_NEIGHBORS          = 64,
    parameter int MAX_SINKS_PER_NEIGHBOR = 8,
    parameter int MAX_KNOWN_SINKS        = 16
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  done_fixSinkList,
    input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
    neighbor_sink_in_other_cluster_if.master mem,
    output logic                  forAggregation2,
    output logic                  done_neighborSinkInOtherCluster
);

    localparam int NW = $clog2(MAX_NEIGHBORS + 1);
    localparam int SW = $clog2(MAX_SINKS_PER_NEIGHBOR + 1);
    localparam int KW = $clog2(MAX_KNOWN_SINKS + 1);

    // Counts read from memory are limited to the table depths.
    function automatic int clamp(input logic [WORD_WIDTH-1:0] v, input int max_v);
        if (int'(v) > max_v) return max_v;
        return int'(v);
    endfunction

    state_t                r_state, w_state_nxt;
    logic                  r_phase, w_phase_nxt;   // 0: address cycle, 1: capture cycle
    logic [NW-1:0]         r_i,     w_i_nxt;
    logic [SW-1:0]         r_j,     w_j_nxt;
    logic [KW-1:0]         r_k,     w_k_nxt;
    logic [NW-1:0]         r_ncnt,  w_ncnt_nxt;
    logic [SW-1:0]         r_scnt,  w_scnt_nxt;
    logic [KW-1:0]         r_kcnt,  w_kcnt_nxt;
    logic [WORD_WIDTH-1:0] r_sid,   w_sid_nxt;
    logic                  r_flag,  w_flag_nxt;

    int w_kc, w_nc, w_sc;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_ncnt  <= '0;
            r_scnt  <= '0;
            r_kcnt  <= '0;
            r_sid   <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_ncnt  <= w_ncnt_nxt;
            r_scnt  <= w_scnt_nxt;
            r_kcnt  <= w_kcnt_nxt;
            r_sid   <= w_sid_nxt;
            r_flag  <= w_flag_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = 1'b0;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_ncnt_nxt  = r_ncnt;
        w_scnt_nxt  = r_scnt;
        w_kcnt_nxt  = r_kcnt;
        w_sid_nxt   = r_sid;
        w_flag_nxt  = r_flag;
        w_kc        = clamp(mem.mem_data_out, MAX_KNOWN_SINKS);
        w_nc        = clamp(mem.mem_data_out, MAX_NEIGHBORS);
        w_sc        = clamp(mem.mem_data_out, MAX_SINKS_PER_NEIGHBOR);

        case (r_state)
            S_IDLE, S_DONE: begin
                if (en && done_fixSinkList) begin
                    w_state_nxt = S_RD_KCNT;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_ncnt_nxt  = '0;
                    w_scnt_nxt  = '0;
                    w_kcnt_nxt  = '0;
                    w_sid_nxt   = '0;
                    w_flag_nxt  = 1'b0;
                end
            end

            S_RD_KCNT: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_kcnt_nxt  = KW'(w_kc);
                    w_state_nxt = (w_kc == 0) ? S_WRITE : S_RD_NCNT;
                end
            end

            S_RD_NCNT: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_ncnt_nxt  = NW'(w_nc);
                    w_state_nxt = (w_nc == 0) ? S_WRITE : S_RD_CID;
                end
            end

            S_RD_CID: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    // Neighbors in our own cluster are not aggregation candidates.
                    w_state_nxt = (mem.mem_data_out == MY_CLUSTER_ID) ? S_NEXT_NBR : S_RD_SCNT;
                end
            end

            S_RD_SCNT: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_scnt_nxt = SW'(w_sc);
                    w_j_nxt    = '0;
                    w_state_nxt = (w_sc == 0) ? S_NEXT_NBR : S_RD_SID;
                end
            end

            S_RD_SID: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_sid_nxt   = mem.mem_data_out;
                    w_k_nxt     = '0;
                    w_state_nxt = S_RD_KS;
                end
            end

            S_RD_KS: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else if (mem.mem_data_out == r_sid) begin
                    // First common sink is enough; skip the rest of the scan.
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = S_WRITE;
                end else if (int'(r_k) + 1 < int'(r_kcnt)) begin
                    w_k_nxt = r_k + 1'b1;
                end else begin
                    w_k_nxt = '0;
                    if (int'(r_j) + 1 < int'(r_scnt)) begin
                        w_j_nxt     = r_j + 1'b1;
                        w_state_nxt = S_RD_SID;
                    end else begin
                        w_state_nxt = S_NEXT_NBR;
                    end
                end
            end

            S_NEXT_NBR: begin
                if (int'(r_i) + 1 >= int'(r_ncnt)) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_i_nxt     = r_i + 1'b1;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_state_nxt = S_RD_CID;
                end
            end

            S_WRITE: w_state_nxt = S_DONE;

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address mux: held for both the address and capture cycle of each access.
    always_comb begin
        mem.address     = '0;
        mem.wr_en       = 1'b0;
        mem.mem_data_in = '0;
        case (r_state)
            S_RD_KCNT: mem.address = ADDR_WIDTH'(KNOWN_SINK_COUNT_ADDR);
            S_RD_NCNT: mem.address = ADDR_WIDTH'(NEIGHBOR_COUNT_ADDR);
            S_RD_CID:  mem.address = ADDR_WIDTH'(CLUSTER_ID_ADDR + 2 * int'(r_i));
            S_RD_SCNT: mem.address = ADDR_WIDTH'(SINK_ID_COUNT_ADDR + 2 * int'(r_i));
            S_RD_SID:  mem.address = ADDR_WIDTH'(SINK_IDS_ADDR + SINK_IDS_STRIDE * int'(r_i)
                                                 + 2 * int'(r_j));
            S_RD_KS:   mem.address = ADDR_WIDTH'(KNOWN_SINKS_ADDR + 2 * int'(r_k));
            S_WRITE: begin
                mem.address     = ADDR_WIDTH'(FLAGS_ADDR);
                mem.wr_en       = 1'b1;
                mem.mem_data_in = {{(WORD_WIDTH-1){1'b0}}, r_flag};
            end
            default: ;
        endcase
    end

    assign forAggregation2                 = r_flag;
    assign done_neighborSinkInOtherCluster = (r_state == S_DONE);

endmodule

// File: tb/tb_neighbor_sink_in_other_cluster.sv
// -----------------------------------------------------------------------------
// tb_neighbor_sink_in_other_cluster
// Directed bench: a behavioural synchronous word memory drives the scanner
// through matching, non-matching, zero-count, blocked-start and reset cases.
// -----------------------------------------------------------------------------
module tb_neighbor_sink_in_other_cluster;

    logic        clock = 1'b0;
    logic        nrst;
    logic        en;
    logic        done_fixSinkList;
    logic [15:0] MY_CLUSTER_ID;
    logic        forAggregation2;
    logic        done_neighborSinkInOtherCluster;

    neighbor_sink_in_other_cluster_if bus ();

    neighbor_sink_in_other_cluster dut (
        .clock                           (clock),
        .nrst                            (nrst),
        .en                              (en),
        .done_fixSinkList                (done_fixSinkList),
        .MY_CLUSTER_ID                   (MY_CLUSTER_ID),
        .mem                             (bus),
        .forAggregation2                 (forAggregation2),
        .done_neighborSinkInOtherCluster (done_neighborSinkInOtherCluster)
    );

    always #5 clock = ~clock;

    // Behavioural memory with a bench-side load port for preloading tables.
    logic [15:0] mem [0:1023];
    logic [15:0] rd_q = 16'h0;
    logic        ld_en = 1'b0;
    logic        clr   = 1'b0;
    logic [10:0] ld_addr = '0;
    logic [15:0] ld_data = '0;

    assign bus.mem_data_out = rd_q;

    always @(posedge clock) begin
        if (clr) begin
            for (int a = 0; a < 1024; a++) mem[a] <= 16'h0;
        end else if (ld_en) begin
            mem[ld_addr[10:1]] <= ld_data;
        end else if (bus.wr_en) begin
            mem[bus.address[10:1]] <= bus.mem_data_in;
        end
        rd_q <= mem[bus.address[10:1]];
    end

    // Bus activity monitor.
    int          wr_cnt  = 0;
    int          act_cnt = 0;
    logic [10:0] last_wr_addr = '0;

    always @(posedge clock) begin
        if (bus.wr_en) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.address;
        end
        if (bus.wr_en || bus.address != '0) act_cnt <= act_cnt + 1;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic load(input logic [10:0] a, input logic [15:0] d);
        @(negedge clock);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clock);
        #1 ld_en = 1'b0;
    endtask

    task automatic clear_mem();
        @(negedge clock);
        clr = 1'b1;
        @(posedge clock);
        #1 clr = 1'b0;
    endtask

    task automatic start(input logic dfs);
        @(negedge clock);
        en               = 1'b1;
        done_fixSinkList = dfs;
        @(posedge clock);
        #1 en = 1'b0;
    endtask

    // Waits up to max_cyc edges for done; a timeout counts as a failed check.
    task automatic wait_done(input string tag, input int max_cyc, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= max_cyc && !seen; c++) begin
            @(posedge clock);
            #1;
            if (done_neighborSinkInOtherCluster) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Base table set: two known sinks, two neighbors with one sink each.
    task automatic load_base();
        clear_mem();
        load(11'h688, 16'd2);
        load(11'h008, 16'h000A);
        load(11'h00A, 16'h000B);
        load(11'h68A, 16'd2);
        load(11'h0C8, 16'd1);
        load(11'h0CA, 16'd2);
        load(11'h68E, 16'd1);
        load(11'h690, 16'd1);
        load(11'h248, 16'h000A);
        load(11'h258, 16'h000B);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, 32'(bus.address), 32'd0);
        check({tag, "_wr"},   32'(bus.wr_en), 32'd0);
        check({tag, "_wdat"}, 32'(bus.mem_data_in), 32'd0);
        check({tag, "_flag"}, 32'(forAggregation2), 32'd0);
        check({tag, "_done"}, 32'(done_neighborSinkInOtherCluster), 32'd0);
    endtask

    initial begin
        int cyc;
        int wr0;
        int act0;

        en               = 1'b0;
        done_fixSinkList = 1'b0;
        MY_CLUSTER_ID    = 16'd1;
        nrst             = 1'b1;

        // Reset from 5 ns to 30 ns.
        #5  nrst = 1'b0;
        #15 check_idle_outputs("reset");
        #10 nrst = 1'b1;

        // Blocked start: upstream not done.
        load_base();
        act0 = act_cnt;
        start(1'b0);
        repeat (10) @(posedge clock);
        #1;
        check("blocked_done", 32'(done_neighborSinkInOtherCluster), 32'd0);
        check("blocked_activity", 32'(act_cnt - act0), 32'd0);

        // Match in another cluster (neighbor 1), neighbor 0 skipped.
        wr0 = wr_cnt;
        start(1'b1);
        check("m1_busy_done", 32'(done_neighborSinkInOtherCluster), 32'd0);
        wait_done("m1_done", 300, cyc);
        check("m1_flag", 32'(forAggregation2), 32'd1);
        check("m1_mem", 32'(mem[2]), 32'd1);
        check("m1_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        check("m1_wr_addr", 32'(last_wr_addr), 32'h004);
        repeat (5) @(posedge clock);
        #1;
        check("m1_hold_done", 32'(done_neighborSinkInOtherCluster), 32'd1);
        check("m1_hold_flag", 32'(forAggregation2), 32'd1);

        // All neighbors in own cluster: no match despite equal sink IDs.
        load(11'h0CA, 16'd1);
        start(1'b1);
        check("own_start_clr_flag", 32'(forAggregation2), 32'd0);
        check("own_start_clr_done", 32'(done_neighborSinkInOtherCluster), 32'd0);
        wait_done("own_done", 300, cyc);
        check("own_flag", 32'(forAggregation2), 32'd0);
        check("own_mem", 32'(mem[2]), 32'd0);

        // Other cluster but no common sink.
        load(11'h0CA, 16'd2);
        load(11'h258, 16'h000C);
        load(11'h004, 16'h0001);
        start(1'b1);
        wait_done("nocommon_done", 300, cyc);
        check("nocommon_flag", 32'(forAggregation2), 32'd0);
        check("nocommon_mem", 32'(mem[2]), 32'd0);

        // neighborCount = 0: done quickly with one write to 0x004.
        load(11'h258, 16'h000B);
        load(11'h68A, 16'd0);
        load(11'h004, 16'h0001);
        wr0 = wr_cnt;
        start(1'b1);
        wait_done("ncnt0_done", 6, cyc);
        check("ncnt0_flag", 32'(forAggregation2), 32'd0);
        check("ncnt0_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        check("ncnt0_wr_addr", 32'(last_wr_addr), 32'h004);
        check("ncnt0_mem", 32'(mem[2]), 32'd0);

        // knownSinkCount = 0 with an otherwise matching table.
        load(11'h68A, 16'd2);
        load(11'h688, 16'd0);
        start(1'b1);
        wait_done("kcnt0_done", 6, cyc);
        check("kcnt0_flag", 32'(forAggregation2), 32'd0);

        // Deeper loops: match on third sink of neighbor vs third known sink.
        clear_mem();
        load(11'h688, 16'd3);
        load(11'h008, 16'h0005);
        load(11'h00A, 16'h0006);
        load(11'h00C, 16'h0007);
        load(11'h68A, 16'd1);
        load(11'h0C8, 16'd9);
        load(11'h68E, 16'd3);
        load(11'h248, 16'h0001);
        load(11'h24A, 16'h0002);
        load(11'h24C, 16'h0007);
        start(1'b1);
        wait_done("deep_done", 300, cyc);
        check("deep_flag", 32'(forAggregation2), 32'd1);
        check("deep_mem", 32'(mem[2]), 32'd1);

        // Full 16-bit compare: 0x1007 must not match known sink 0x0007.
        load(11'h24C, 16'h1007);
        start(1'b1);
        wait_done("wide_done", 300, cyc);
        check("wide_flag", 32'(forAggregation2), 32'd0);

        // Reset mid-scan: abort with no write.
        load_base();
        load(11'h004, 16'h0055);
        wr0 = wr_cnt;
        start(1'b1);
        repeat (6) @(posedge clock);
        #3 nrst = 1'b0;
        #1 check_idle_outputs("midrst");
        repeat (3) @(posedge clock);
        #1;
        check("midrst_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
        check("midrst_mem", 32'(mem[2]), 32'h0055);
        nrst = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("midrst_after_done", 32'(done_neighborSinkInOtherCluster), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
